// File: rtl/alu_rf_pkg.sv
// alu_rf_pkg: shared constants and helpers for the ALU operand register file.
// Holds the legacy operand bank values that registers reload on reset/clear.
package alu_rf_pkg;

    localparam int RF_NINIT = 4;

    localparam logic [7:0] RF_INIT [RF_NINIT] = '{8'h48, 8'hAF, 8'hCC, 8'h32};

    // Reset value of register i at data width 'width' (truncated or zero-extended).
    function automatic logic [63:0] init_val(input int i, input int width);
        logic [63:0] v;
        v = '0;
        if (i >= 0 && i < RF_NINIT) begin
            v = 64'(RF_INIT[i[1:0]]);
        end
        if (width < 64) begin
            v = v & ((64'd1 << width) - 64'd1);
        end
        return v;
    endfunction

endpackage

// File: rtl/alu_rf_read_port.sv
// alu_rf_read_port: one registered read port of the ALU operand register file.
// Optional same-cycle write forwarding when ALU_RF_BYPASS_EN is defined.
module alu_rf_read_port
    import alu_rf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AW-1:0]               addr,
    input  logic [DEPTH-1:0][WIDTH-1:0] regs,
`ifdef ALU_RF_BYPASS_EN
    input  logic                        fwd_en,
    input  logic [AW-1:0]               fwd_addr,
    input  logic [WIDTH-1:0]            fwd_data,
`endif
    output logic [WIDTH-1:0]            data
);

    logic [WIDTH-1:0] nxt;

    // Storage mux; addresses past DEPTH match no entry and read as zero.
    always_comb begin
        nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == AW'(i)) begin
                nxt = regs[i];
            end
        end
`ifdef ALU_RF_BYPASS_EN
        if (fwd_en && fwd_addr == addr) begin
            nxt = fwd_data;
        end
`endif
    end

    // Output register, one cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else begin
            data <= nxt;
        end
    end

endmodule

// File: rtl/alu_regfile.sv
// alu_regfile: writable operand register file, 2 read ports, 1 write port.
// Build option ALU_RF_BYPASS_EN: forward same-cycle write data to reads.
module alu_regfile
    import alu_rf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd0_addr,
    input  logic [AW-1:0]    rd1_addr,
    output logic [WIDTH-1:0] rd0_data,
    output logic [WIDTH-1:0] rd1_data,
    output logic             wr_err
);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic                        wr_in;
    logic                        wr_ok;

    // Write address range check and qualified write strobe.
    always_comb begin
        wr_in = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
        wr_ok = wr_en && wr_in;
    end

    // Storage: reset/clear reload the legacy operands, clear wins over write.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= WIDTH'(init_val(i, WIDTH));
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && wr_addr == AW'(i)) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Flag a write to an out-of-range address for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_in;
        end
    end

    alu_rf_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rd0 (
        .clk      (clk),
        .rst      (rst),
        .addr     (rd0_addr),
        .regs     (regs),
`ifdef ALU_RF_BYPASS_EN
        .fwd_en   (wr_ok && !clr),
        .fwd_addr (wr_addr),
        .fwd_data (wr_data),
`endif
        .data     (rd0_data)
    );

    alu_rf_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rd1 (
        .clk      (clk),
        .rst      (rst),
        .addr     (rd1_addr),
        .regs     (regs),
`ifdef ALU_RF_BYPASS_EN
        .fwd_en   (wr_ok && !clr),
        .fwd_addr (wr_addr),
        .fwd_data (wr_data),
`endif
        .data     (rd1_data)
    );

endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: directed checks of alu_regfile at DEPTH=4 and DEPTH=6.
// Expected values are hand-computed constants.
module tb_alu_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // DEPTH=4 instance
    logic       a_rst = 1'b1, a_clr = 1'b0, a_wen = 1'b0;
    logic [1:0] a_waddr = '0, a_r0 = '0, a_r1 = '0;
    logic [7:0] a_wdata = '0, a_d0, a_d1;
    logic       a_err;

    // DEPTH=6 instance
    logic       b_rst = 1'b1, b_clr = 1'b0, b_wen = 1'b0;
    logic [2:0] b_waddr = '0, b_r0 = '0, b_r1 = '0;
    logic [7:0] b_wdata = '0, b_d0, b_d1;
    logic       b_err;

    logic [7:0] init_tab [6] = '{8'h48, 8'hAF, 8'hCC, 8'h32, 8'h00, 8'h00};
    logic [7:0] coll_exp;

    alu_regfile #(.WIDTH(8), .DEPTH(4)) u_a (
        .clk(clk), .rst(a_rst), .clr(a_clr), .wr_en(a_wen),
        .wr_addr(a_waddr), .wr_data(a_wdata),
        .rd0_addr(a_r0), .rd1_addr(a_r1),
        .rd0_data(a_d0), .rd1_data(a_d1), .wr_err(a_err)
    );

    alu_regfile #(.WIDTH(8), .DEPTH(6)) u_b (
        .clk(clk), .rst(b_rst), .clr(b_clr), .wr_en(b_wen),
        .wr_addr(b_waddr), .wr_data(b_wdata),
        .rd0_addr(b_r0), .rd1_addr(b_r1),
        .rd0_data(b_d0), .rd1_data(b_d1), .wr_err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef ALU_RF_BYPASS_EN
        coll_exp = 8'h77;
`else
        coll_exp = 8'h32;
`endif
        // reset both instances for two cycles
        step();
        step();
        a_rst = 1'b0;
        b_rst = 1'b0;
        check("rst_rd0", 32'(a_d0), 32'h00);
        check("rst_rd1", 32'(a_d1), 32'h00);
        check("rst_err", 32'(a_err), 32'h0);

        // reset contents on both ports
        for (int i = 0; i < 4; i++) begin
            a_r0 = 2'(i);
            a_r1 = 2'(3 - i);
            step();
            check($sformatf("init_rd0_%0d", i), 32'(a_d0), 32'(init_tab[i]));
            check($sformatf("init_rd1_%0d", 3 - i), 32'(a_d1), 32'(init_tab[3 - i]));
        end

        // write then read
        a_wen = 1'b1; a_waddr = 2'd2; a_wdata = 8'h5A;
        a_r0 = 2'd0; a_r1 = 2'd0;
        step();
        a_wen = 1'b0;
        a_r0 = 2'd2; a_r1 = 2'd1;
        step();
        check("wr_rd0", 32'(a_d0), 32'h5A);
        check("wr_rd1", 32'(a_d1), 32'hAF);

        // same-cycle read/write collision
        a_wen = 1'b1; a_waddr = 2'd3; a_wdata = 8'h77;
        a_r0 = 2'd3; a_r1 = 2'd2;
        step();
        a_wen = 1'b0;
        check("coll_rd0", 32'(a_d0), 32'(coll_exp));
        check("coll_rd1", 32'(a_d1), 32'h5A);
        step();
        check("coll_after", 32'(a_d0), 32'h77);

        // clear beats write
        a_wen = 1'b1; a_waddr = 2'd0; a_wdata = 8'h11;
        step();
        a_clr = 1'b1; a_waddr = 2'd1; a_wdata = 8'h22;
        a_r0 = 2'd0; a_r1 = 2'd1;
        step();
        check("clr_pre_rd0", 32'(a_d0), 32'h11);
        check("clr_pre_rd1", 32'(a_d1), 32'hAF);
        a_clr = 1'b0; a_wen = 1'b0;
        step();
        check("clr_rd0", 32'(a_d0), 32'h48);
        check("clr_rd1", 32'(a_d1), 32'hAF);
        a_r0 = 2'd2; a_r1 = 2'd3;
        step();
        check("clr_rd2", 32'(a_d0), 32'hCC);
        check("clr_rd3", 32'(a_d1), 32'h32);

        // reset during traffic
        a_wen = 1'b1; a_waddr = 2'd1; a_wdata = 8'hEE;
        step();
        a_rst = 1'b1; a_waddr = 2'd2; a_wdata = 8'hFF;
        a_r0 = 2'd1; a_r1 = 2'd1;
        step();
        check("mrst_rd0", 32'(a_d0), 32'h00);
        check("mrst_rd1", 32'(a_d1), 32'h00);
        check("mrst_err", 32'(a_err), 32'h0);
        a_rst = 1'b0; a_wen = 1'b0;
        a_r0 = 2'd2; a_r1 = 2'd1;
        step();
        check("mrst_reg2", 32'(a_d0), 32'hCC);
        check("mrst_reg1", 32'(a_d1), 32'hAF);

        // DEPTH=6: out-of-range write
        b_wen = 1'b1; b_waddr = 3'd7; b_wdata = 8'h99;
        step();
        b_wen = 1'b0;
        check("oor_err", 32'(b_err), 32'h1);
        step();
        check("oor_err_clr", 32'(b_err), 32'h0);
        for (int i = 0; i < 6; i += 2) begin
            b_r0 = 3'(i);
            b_r1 = 3'(i + 1);
            step();
            check($sformatf("oor_reg%0d", i), 32'(b_d0), 32'(init_tab[i]));
            check($sformatf("oor_reg%0d", i + 1), 32'(b_d1), 32'(init_tab[i + 1]));
        end

        // out-of-range reads, in-range write leaves wr_err low
        b_wen = 1'b1; b_waddr = 3'd5; b_wdata = 8'h3C;
        b_r0 = 3'd6; b_r1 = 3'd7;
        step();
        b_wen = 1'b0;
        check("oor_rd6", 32'(b_d0), 32'h00);
        check("oor_rd7", 32'(b_d1), 32'h00);
        check("inr_err", 32'(b_err), 32'h0);
        b_r0 = 3'd5; b_r1 = 3'd6;
        step();
        check("b_rd5", 32'(b_d0), 32'h3C);
        check("b_rd6", 32'(b_d1), 32'h00);

        // wr_err still raised when clr hides the write
        b_clr = 1'b1; b_wen = 1'b1; b_waddr = 3'd6; b_wdata = 8'h55;
        step();
        b_clr = 1'b0; b_wen = 1'b0;
        check("clr_oor_err", 32'(b_err), 32'h1);
        step();
        check("b_clr_rd5", 32'(b_d0), 32'h00);

        // reset returns reg5 to zero
        b_wen = 1'b1; b_waddr = 3'd5; b_wdata = 8'hA5;
        step();
        b_wen = 1'b0;
        step();
        check("b_wr5", 32'(b_d0), 32'hA5);
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        step();
        check("b_rst_rd5", 32'(b_d0), 32'h00);
        check("b_rst_rd6", 32'(b_d1), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
